// File: rtl/core_mem_responder_pkg.sv
// Shared types and constants for the core memory responder: bus widths,
// request/response records and the byte-lane merge helper.
package core_mem_responder_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 64;
    localparam int BEATSIZE   = 8;
    localparam int NUM_LANES  = DATA_WIDTH / BEATSIZE;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NUM_LANES-1:0]  beat;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  rwrite;
        logic                  err;
    } mem_rsp_t;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NUM_LANES-1:0]  beat
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (beat[i]) begin
                res[i*BEATSIZE +: BEATSIZE] = new_w[i*BEATSIZE +: BEATSIZE];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// Request/response bus between an initiator (core LSU or fetch port) and the
// memory responder.
interface core_mem_responder_if
    import core_mem_responder_pkg::*;
();
    logic                  req_i;
    logic                  grnt_o;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic                  wen_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [NUM_LANES-1:0]  beat_i;
    logic                  rvalid_o;
    logic                  rready_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  rwrite_o;
    logic                  err_o;
    logic                  busy_o;

    modport master (
        output req_i, addr_i, wen_i, wdata_i, beat_i, rready_i,
        input  grnt_o, rvalid_o, rdata_o, rwrite_o, err_o, busy_o
    );

    modport slave (
        input  req_i, addr_i, wen_i, wdata_i, beat_i, rready_i,
        output grnt_o, rvalid_o, rdata_o, rwrite_o, err_o, busy_o
    );
endinterface

// File: rtl/core_mem_responder_chk.sv
// Simulation checks on the responder's handshake and internal bounds.
module core_mem_responder_chk
    import core_mem_responder_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int OW              = 3
) (
    input logic          clk_i,
    input logic          rst_n_i,
    input logic          req_i,
    input logic          grnt_i,
    input mem_req_t      req_data_i,
    input logic          push_i,
    input logic          full_i,
    input logic [OW-1:0] outstanding_i
);
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (req_i && !grnt_i) |=> $stable(req_data_i));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && full_i));

    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        outstanding_i <= OW'(MAX_OUTSTANDING));
endmodule

// File: rtl/core_resp_fifo.sv
// First-word-fall-through response FIFO; the head entry is visible while
// not empty and is removed on pop.
module core_resp_fifo
    import core_mem_responder_pkg::*;
#(
    parameter type T     = mem_rsp_t,
    parameter int  DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic push_i,
    input  T     push_data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign head_o    = mem_q[rd_ptr_q];

    // next pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) wr_ptr_d = ptr_inc(wr_ptr_q); else wr_ptr_d = wr_ptr_q;
        if (do_pop_s)  rd_ptr_d = ptr_inc(rd_ptr_q); else rd_ptr_d = rd_ptr_q;
        cnt_d = cnt_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // pointer/count state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // entry storage, no reset needed since occupancy guards every read
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder: word storage with byte-lane writes, fixed read
// latency and a bounded number of in-order outstanding responses.
module core_mem_responder
    import core_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    core_mem_responder_if.slave bus
);
    localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = $clog2(DEPTH_WORDS);
    localparam int OW         = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
    mem_req_t              req_s;
    mem_rsp_t              rsp_in_s, pipe_out_s, head_s;
    logic [ADDR_WIDTH-1:0] widx_full_s;
    logic [IDX_W-1:0]      widx_s;
    logic                  err_s, grant_s, push_s, pop_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic [OW-1:0]         out_q, out_d;

    assign req_s.addr  = bus.addr_i;
    assign req_s.wen   = bus.wen_i;
    assign req_s.wdata = bus.wdata_i;
    assign req_s.beat  = bus.beat_i;

    // Byte offset bits are dropped; anything beyond the array is an error, never a wrap.
    assign widx_full_s = req_s.addr >> WORD_SHIFT;
    assign err_s       = (widx_full_s >= ADDR_WIDTH'(DEPTH_WORDS));
    assign widx_s      = widx_full_s[IDX_W-1:0];

    // The count is registered, so a pop frees a slot only from the next cycle.
    assign grant_s    = bus.req_i & rst_n_i & (out_q < OW'(MAX_OUTSTANDING));
    assign bus.grnt_o = grant_s;

    // response formed from storage as seen at the grant edge
    always_comb begin
        rsp_in_s.rwrite = req_s.wen;
        rsp_in_s.err    = err_s;
        if (!req_s.wen && !err_s) rsp_in_s.rdata = mem_q[widx_s];
        else                      rsp_in_s.rdata = '0;
    end

    // storage write with byte-lane enables; contents survive reset
    always_ff @(posedge clk_i) begin
        if (grant_s && req_s.wen && !err_s) begin
            mem_q[widx_s] <= merge_lanes(mem_q[widx_s], req_s.wdata, req_s.beat);
        end
    end

    // The FIFO push edge is the last latency stage, so only LATENCY-1 registers precede it.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign push_s     = grant_s;
            assign pipe_out_s = rsp_in_s;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;
            mem_rsp_t          pipe_q [STAGES];
            logic [STAGES-1:0] vld_q;

            // latency shift pipe
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    vld_q <= '0;
                    for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
                end else begin
                    vld_q[0]  <= grant_s;
                    pipe_q[0] <= rsp_in_s;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign push_s     = vld_q[STAGES-1];
            assign pipe_out_s = pipe_q[STAGES-1];
        end
    endgenerate

    core_resp_fifo #(.T(mem_rsp_t), .DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push_s),
        .push_data_i (pipe_out_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    assign pop_s        = ~fifo_empty_s & bus.rready_i;
    assign bus.rvalid_o = ~fifo_empty_s;
    assign bus.rdata_o  = fifo_empty_s ? '0   : head_s.rdata;
    assign bus.rwrite_o = fifo_empty_s ? 1'b0 : head_s.rwrite;
    assign bus.err_o    = fifo_empty_s ? 1'b0 : head_s.err;
    assign bus.busy_o   = (out_q != '0);

    // outstanding counter next state
    always_comb begin
        out_d = out_q;
        case ({grant_s, pop_s})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // outstanding counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) out_q <= '0;
        else          out_q <= out_d;
    end

    core_mem_responder_chk #(.MAX_OUTSTANDING(MAX_OUTSTANDING), .OW(OW)) u_chk (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_i         (bus.req_i),
        .grnt_i        (grant_s),
        .req_data_i    (req_s),
        .push_i        (push_s),
        .full_i        (fifo_full_s),
        .outstanding_i (out_q)
    );

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: byte-level reference memory,
// directed scenarios followed by a randomized traffic phase.
module tb_core_mem_responder;
    import core_mem_responder_pkg::*;

    localparam int LATENCY = 2;
    localparam int MAXO    = 4;
    localparam int DEPTH   = 1024;

    typedef struct {
        logic [63:0] rdata;
        logic        rwrite;
        logic        err;
        int          gcyc;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  beat;
    } op_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    core_mem_responder_if bus();

    core_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    op_t         stim_q[$];
    logic [7:0]  ref_bytes [longint];
    logic [63:0] prep_val [16];
    int          total = 0, bad = 0;
    int          cyc = 0, n_grants = 0, last_gcyc = 0, last_issue = 0, n_err_rsp = 0;
    int          rdy_mode = 1;
    logic [63:0] last_rdata = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic op_t mk(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] b);
        op_t o;
        o.addr = a; o.wen = w; o.wdata = d; o.beat = b;
        return o;
    endfunction

    // Reference: memory as individual bytes addressed by word*8+lane.
    function automatic exp_t model(input op_t op);
        exp_t   e;
        longint base;
        e.rwrite = op.wen;
        e.err    = 1'b0;
        e.rdata  = 64'd0;
        e.gcyc   = cyc + 1;
        if ((op.addr / 64'd8) >= 64'(DEPTH)) begin
            e.err = 1'b1;
        end else begin
            base = longint'(op.addr / 64'd8) * 8;
            for (int l = 0; l < 8; l++) begin
                if (op.wen && op.beat[l]) ref_bytes[base + l] = op.wdata[8*l +: 8];
                if (!op.wen) e.rdata[8*l +: 8] = ref_bytes.exists(base + l) ? ref_bytes[base + l] : 8'h00;
            end
        end
        return e;
    endfunction

    initial begin : driver
        op_t cur;
        bit  took;
        cur = mk(64'h4000, 1'b0, 64'd0, 8'h00);
        bus.addr_i  = cur.addr;
        bus.wen_i   = cur.wen;
        bus.wdata_i = cur.wdata;
        bus.beat_i  = cur.beat;
        bus.req_i   = 1'b1;
        forever begin
            @(negedge clk);
            took = 0;
            if (bus.req_i && bus.grnt_o) begin
                exp_q.push_back(model(cur));
                took = 1;
                n_grants++;
                last_gcyc = cyc + 1;
            end
            @(posedge clk);
            #1;
            if (took || !bus.req_i) begin
                if (stim_q.size() > 0) begin
                    cur = stim_q.pop_front();
                    bus.addr_i  = cur.addr;
                    bus.wen_i   = cur.wen;
                    bus.wdata_i = cur.wdata;
                    bus.beat_i  = cur.beat;
                    bus.req_i   = 1'b1;
                    last_issue  = cyc;
                end else begin
                    bus.req_i = 1'b0;
                end
            end
        end
    end

    initial begin : rdy_drv
        bus.rready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rready_i = 1'b0;
                1:       bus.rready_i = 1'b1;
                default: bus.rready_i = ($urandom % 10) < 7;
            endcase
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rvalid_o && bus.rready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got rvalid=1 required no response pending");
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", bus.rdata_o, e.rdata);
                    check("rsp_flags", {62'd0, bus.rwrite_o, bus.err_o}, {62'd0, e.rwrite, e.err});
                    check("rsp_latency", 64'((cyc - e.gcyc) >= (LATENCY - 1)), 64'd1);
                    if (!e.rwrite) last_rdata = bus.rdata_o;
                    if (bus.err_o) n_err_rsp++;
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((stim_q.size() != 0 || bus.req_i || exp_q.size() != 0 || bus.busy_o) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 64'(n < budget), 64'd1);
    endtask

    initial begin : main
        int g0, g, n, e0;
        logic [63:0] a;
        #1 rst_n = 1'b0;
        #1;
        check("rst_grnt",   64'(bus.grnt_o),   64'd0);
        check("rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("rst_busy",   64'(bus.busy_o),   64'd0);
        check("rst_rdata",  bus.rdata_o,       64'd0);
        check("rst_flags",  64'({bus.rwrite_o, bus.err_o}), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prep_val[i] = {$urandom, $urandom};
            stim_q.push_back(mk(64'(i * 8), 1'b1, prep_val[i], 8'hFF));
        end
        wait_idle("prep", 500);

        // 1: full write, exact response timing
        g0 = n_grants;
        stim_q.push_back(mk(64'h10, 1'b1, 64'h1122334455667788, 8'hFF));
        n = 0;
        while (n_grants == g0 && n < 50) begin @(negedge clk); n++; end
        check("t1_granted", 64'(n < 50), 64'd1);
        g = last_gcyc;
        check("t1_grant_same_cycle", 64'(last_gcyc - last_issue), 64'd1);
        while (cyc < g) @(negedge clk);
        check("t1_rvalid_early", 64'(bus.rvalid_o), 64'd0);
        @(negedge clk);
        check("t1_rvalid", 64'(bus.rvalid_o), 64'd1);
        check("t1_rwrite", 64'(bus.rwrite_o), 64'd1);
        check("t1_rdata",  bus.rdata_o,       64'd0);
        wait_idle("t1", 100);

        // 2: partial lane write then read
        stim_q.push_back(mk(64'h10, 1'b1, 64'hAAAAAAAA_BBBBBBBB, 8'h0F));
        stim_q.push_back(mk(64'h10, 1'b0, 64'd0, 8'h00));
        wait_idle("t2", 100);
        check("t2_partial", last_rdata, 64'h11223344_BBBBBBBB);

        // 3: write/read back to back on one word
        stim_q.push_back(mk(64'h20, 1'b1, 64'hCAFEF00D_12345678, 8'hFF));
        stim_q.push_back(mk(64'h23, 1'b0, 64'd0, 8'h00));
        stim_q.push_back(mk(64'h20, 1'b1, 64'h00005555_00000000, 8'h30));
        stim_q.push_back(mk(64'h20, 1'b0, 64'd0, 8'h00));
        wait_idle("t3", 100);
        check("t3_rmw", last_rdata, 64'hCAFE5555_12345678);

        // 4: backpressure saturates the grant limit
        rdy_mode = 0;
        @(posedge clk); #2;
        g0 = n_grants;
        for (int i = 0; i < 6; i++) stim_q.push_back(mk(64'(i * 8 + 16 * 8) - 64'(16 * 8) + 64'($urandom_range(0, 7)), 1'b0, 64'd0, 8'h00));
        repeat (15) @(negedge clk);
        check("t4_grants_held", 64'(n_grants - g0), 64'd4);
        check("t4_grnt_low",    64'(bus.grnt_o),     64'd0);
        check("t4_busy",        64'(bus.busy_o),     64'd1);
        check("t4_req_waiting", 64'(bus.req_i),      64'd1);
        rdy_mode = 1;
        wait_idle("t4", 100);
        check("t4_grants_all", 64'(n_grants - g0), 64'd6);
        check("t4_last_read", last_rdata, prep_val[5]);

        // 5: out-of-range read and write, no alias of word 0
        e0 = n_err_rsp;
        a  = 64'(DEPTH * 8);
        stim_q.push_back(mk(a, 1'b0, 64'd0, 8'h00));
        stim_q.push_back(mk(a, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF));
        stim_q.push_back(mk(64'h0, 1'b0, 64'd0, 8'h00));
        wait_idle("t5", 100);
        check("t5_err_count", 64'(n_err_rsp - e0), 64'd2);
        check("t5_word0_intact", last_rdata, prep_val[0]);

        // 6: reset with responses in flight
        rdy_mode = 0;
        @(posedge clk); #2;
        g0 = n_grants;
        stim_q.push_back(mk(64'h08, 1'b0, 64'd0, 8'h00));
        stim_q.push_back(mk(64'h18, 1'b0, 64'd0, 8'h00));
        stim_q.push_back(mk(64'h28, 1'b0, 64'd0, 8'h00));
        n = 0;
        while (n_grants - g0 < 3 && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("t6_pending", 64'(bus.rvalid_o), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", 64'(bus.rvalid_o), 64'd0);
        check("t6_rst_busy",   64'(bus.busy_o),   64'd0);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        rdy_mode = 1;
        repeat (10) @(negedge clk);
        check("t6_no_stale", 64'(bus.rvalid_o), 64'd0);
        check("t6_idle_busy", 64'(bus.busy_o), 64'd0);
        stim_q.push_back(mk(64'h10, 1'b0, 64'd0, 8'h00));
        wait_idle("t6", 100);
        check("t6_write_kept", last_rdata, 64'h11223344_BBBBBBBB);

        // random traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            a = 64'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 100000));
            stim_q.push_back(mk(a, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 8'($urandom_range(0, 255))));
        end
        wait_idle("rand", 5000);
        rdy_mode = 1;
        check("final_busy", 64'(bus.busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
